op_issue_seq: RTL and testbench

- Initiator for four-operand STB/BUSY floating-point operation units, such as the (a*b)*(c*d) operation unit.
- Collects four 32-bit IEEE-754 words one at a time from an upstream command stream, issues them to the unit, and captures the unit's result.
- Returns the result on a response handshake.
- Sits between the RoCC command/response glue and any operationN unit. Provides a watchdog so a hung unit cannot stall the accelerator.

---
 rtl/op_issue_seq.sv | 147 ++++++++++++++
 tb/tb_op_issue_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : op_issue_seq
// Brief    : Collects four operand words from an upstream stream, issues them
//            to a four-operand STB/BUSY operation unit, captures its result
//            and returns it on a response handshake, with a watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module op_issue_seq #(
    parameter int                 DATA_W         = 32,
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]  ABORT_VALUE    = DATA_W'(32'h7FC00000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_STB,
    output logic              in_BUSY,
    output logic [DATA_W-1:0] op_input_a,
    output logic [DATA_W-1:0] op_input_b,
    output logic [DATA_W-1:0] op_input_c,
    output logic [DATA_W-1:0] op_input_d,
    output logic              op_input_STB,
    input  logic              op_BUSY,
    input  logic [DATA_W-1:0] op_output_result,
    input  logic              op_output_STB,
    output logic              op_output_module_BUSY,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_STB,
    input  logic              resp_BUSY,
    output logic              timeout_err,
    output logic [15:0]       op_count
);

    localparam logic [1:0]  c_COLLECT  = 2'd0;
    localparam logic [1:0]  c_ISSUE    = 2'd1;
    localparam logic [1:0]  c_WAIT     = 2'd2;
    localparam logic [1:0]  c_RESPOND  = 2'd3;
    localparam logic [15:0] c_WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_idx;
    logic [15:0]       r_wd;
    logic              r_in_busy;
    logic              r_op_stb;
    logic              r_mod_busy;
    logic              r_resp_stb;
    logic [DATA_W-1:0] r_resp_data;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] r_d;
    logic              r_terr;
    logic [15:0]       r_op_count;
    logic              w_progress;

    // Forward progress for whichever watched state is active.
    assign w_progress = (r_state == c_ISSUE) ? (r_op_stb && op_BUSY) : op_output_STB;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_COLLECT;
            r_idx       <= 2'd0;
            r_wd        <= 16'd0;
            r_in_busy   <= 1'b0;
            r_op_stb    <= 1'b0;
            r_mod_busy  <= 1'b1;
            r_resp_stb  <= 1'b0;
            r_resp_data <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_terr      <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            case (r_state)
                c_COLLECT: begin
                    if (in_STB && !r_in_busy) begin
                        case (r_idx)
                            2'd0:    r_a <= in_data;
                            2'd1:    r_b <= in_data;
                            2'd2:    r_c <= in_data;
                            default: r_d <= in_data;
                        endcase
                        if (r_idx == 2'd3) begin
                            r_idx     <= 2'd0;
                            r_in_busy <= 1'b1;
                            r_op_stb  <= 1'b1;
                            r_wd      <= 16'd0;
                            r_state   <= c_ISSUE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                c_ISSUE, c_WAIT: begin
                    // Progress takes priority over a coincident timeout.
                    if (w_progress) begin
                        r_wd <= r_wd + 16'd1;
                        if (r_state == c_ISSUE) begin
                            r_op_stb   <= 1'b0;
                            r_mod_busy <= 1'b0;
                            r_state    <= c_WAIT;
                        end else begin
                            r_resp_data <= op_output_result;
                            r_mod_busy  <= 1'b1;
                            r_resp_stb  <= 1'b1;
                            r_state     <= c_RESPOND;
                        end
                    end else if (r_wd == c_WD_LIMIT) begin
                        r_op_stb    <= 1'b0;
                        r_mod_busy  <= 1'b1;
                        r_resp_data <= ABORT_VALUE;
                        r_terr      <= 1'b1;
                        r_resp_stb  <= 1'b1;
                        r_state     <= c_RESPOND;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                default: begin
                    if (!resp_BUSY) begin
                        r_resp_stb <= 1'b0;
                        r_op_count <= r_op_count + 16'd1;
                        r_in_busy  <= 1'b0;
                        r_state    <= c_COLLECT;
                    end
                end
            endcase
        end
    end

    assign in_BUSY               = r_in_busy;
    assign op_input_a            = r_a;
    assign op_input_b            = r_b;
    assign op_input_c            = r_c;
    assign op_input_d            = r_d;
    assign op_input_STB          = r_op_stb;
    assign op_output_module_BUSY = r_mod_busy;
    assign resp_data             = r_resp_data;
    assign resp_STB              = r_resp_stb;
    assign timeout_err           = r_terr;
    assign op_count              = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_op_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_issue_seq
// Brief    : Directed bench for op_issue_seq with a behavioural (a*b)*(c*d) unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_op_issue_seq;

    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_STB = 1'b0;
    logic              in_BUSY;
    logic [DATA_W-1:0] op_input_a, op_input_b, op_input_c, op_input_d;
    logic              op_input_STB;
    logic              op_BUSY;
    logic [DATA_W-1:0] op_output_result;
    logic              op_output_STB;
    logic              op_output_module_BUSY;
    logic [DATA_W-1:0] resp_data;
    logic              resp_STB;
    logic              resp_BUSY = 1'b0;
    logic              timeout_err;
    logic [15:0]       op_count;

    int checks    = 0;
    int failures  = 0;
    int exp_count = 0;

    op_issue_seq #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ABORT_VALUE    (32'h7FC00000)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_data               (in_data),
        .in_STB                (in_STB),
        .in_BUSY               (in_BUSY),
        .op_input_a            (op_input_a),
        .op_input_b            (op_input_b),
        .op_input_c            (op_input_c),
        .op_input_d            (op_input_d),
        .op_input_STB          (op_input_STB),
        .op_BUSY               (op_BUSY),
        .op_output_result      (op_output_result),
        .op_output_STB         (op_output_STB),
        .op_output_module_BUSY (op_output_module_BUSY),
        .resp_data             (resp_data),
        .resp_STB              (resp_STB),
        .resp_BUSY             (resp_BUSY),
        .timeout_err           (timeout_err),
        .op_count              (op_count)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        if (e > 0) repeat (e) m = m * 2.0;
        else       repeat (-e) m = m / 2.0;
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic [63:0] b;
        logic [10:0] e;
        if (x == 0.0) return 32'h0;
        b = $realtobits(x);
        e = b[62:52];
        return {b[63], 8'(e - 11'd896), b[51:29]};
    endfunction

    function automatic logic [31:0] fmul4(input logic [31:0] a, b, c, d);
        return r2f((f2r(a) * f2r(b)) * (f2r(c) * f2r(d)));
    endfunction

    // Behavioural operation unit: latches operands, answers after m_lat cycles.
    logic        m_busy, m_ostb;
    logic [31:0] m_res;
    int          m_cnt;
    int          m_lat  = 2;
    bit          m_hang = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_ostb <= 1'b0;
            m_res  <= '0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (op_input_STB && !m_hang) begin
                m_busy <= 1'b1;
                m_res  <= fmul4(op_input_a, op_input_b, op_input_c, op_input_d);
                m_cnt  <= m_lat;
            end
        end else if (!m_ostb) begin
            if (m_cnt == 0) m_ostb <= 1'b1;
            else            m_cnt  <= m_cnt - 1;
        end else if (!op_output_module_BUSY) begin
            m_ostb <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    assign op_BUSY          = m_busy;
    assign op_output_STB    = m_ostb;
    assign op_output_result = m_res;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] data, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data = data;
        in_STB  = 1'b1;
        n = 0;
        while (in_BUSY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_value("send_wait", {31'd0, in_BUSY}, 32'd0);
        @(negedge clk);
        in_STB = 1'b0;
    endtask

    task automatic send_set(input logic [31:0] a, b, c, d, input int gap);
        send_word(a, gap);
        send_word(b, gap);
        send_word(c, gap);
        send_word(d, gap);
    endtask

    task automatic get_resp(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!resp_STB && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_stb"}, {31'd0, resp_STB}, 32'd1);
        check_value({tag, "_data"}, resp_data, exp);
        @(negedge clk);
        exp_count++;
        check_value({tag, "_cnt"}, {16'd0, op_count}, 32'(exp_count));
        check_value({tag, "_stb_low"}, {31'd0, resp_STB}, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;
    endtask

    initial begin
        int n;
        int hits;
        logic [31:0] w [4];

        repeat (3) @(negedge clk);
        check_value("rst_in_busy",  {31'd0, in_BUSY}, 32'd0);
        check_value("rst_op_stb",   {31'd0, op_input_STB}, 32'd0);
        check_value("rst_mod_busy", {31'd0, op_output_module_BUSY}, 32'd1);
        check_value("rst_resp_stb", {31'd0, resp_STB}, 32'd0);
        check_value("rst_resp_data", resp_data, 32'd0);
        check_value("rst_op_a", op_input_a, 32'd0);
        check_value("rst_terr", {31'd0, timeout_err}, 32'd0);
        check_value("rst_count", {16'd0, op_count}, 32'd0);
        rst = 1'b1;

        // Basic: 2*3*4*0.5 = 12.0
        m_lat = 2;
        send_set(32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000, 0);
        check_value("basic_op_stb", {31'd0, op_input_STB}, 32'd1);
        check_value("basic_in_busy", {31'd0, in_BUSY}, 32'd1);
        check_value("basic_a", op_input_a, 32'h40000000);
        check_value("basic_b", op_input_b, 32'h40400000);
        check_value("basic_c", op_input_c, 32'h40800000);
        check_value("basic_d", op_input_d, 32'h3F000000);
        get_resp("basic", 32'h41400000);
        check_value("basic_terr", {31'd0, timeout_err}, 32'd0);

        // Gapped upstream, 10 cycles of downstream backpressure: 1*5*(-2)*0.25 = -2.5
        resp_BUSY = 1'b1;
        send_set(32'h3F800000, 32'h40A00000, 32'hC0000000, 32'h3E800000, 1);
        check_value("gap_a", op_input_a, 32'h3F800000);
        check_value("gap_b", op_input_b, 32'h40A00000);
        check_value("gap_c", op_input_c, 32'hC0000000);
        check_value("gap_d", op_input_d, 32'h3E800000);
        n = 0;
        while (!resp_STB && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check_value("bp_stb", {31'd0, resp_STB}, 32'd1);
            check_value("bp_data", resp_data, 32'hC0200000);
            check_value("bp_in_busy", {31'd0, in_BUSY}, 32'd1);
            @(negedge clk);
        end
        resp_BUSY = 1'b0;
        @(negedge clk);
        exp_count++;
        check_value("bp_cnt", {16'd0, op_count}, 32'(exp_count));
        check_value("bp_stb_low", {31'd0, resp_STB}, 32'd0);
        check_value("bp_in_free", {31'd0, in_BUSY}, 32'd0);

        // Fifth word offered during ISSUE must wait for the response.
        m_lat = 3;
        send_set(32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000, 0);
        in_data = 32'h40E00000;
        in_STB  = 1'b1;
        check_value("extra_held", {31'd0, in_BUSY}, 32'd1);
        n = 0;
        while (!resp_STB && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("extra_resp", resp_data, 32'h41400000);
        check_value("extra_a_kept", op_input_a, 32'h40000000);
        check_value("extra_busy_resp", {31'd0, in_BUSY}, 32'd1);
        @(negedge clk);
        exp_count++;
        check_value("extra_cnt", {16'd0, op_count}, 32'(exp_count));
        @(negedge clk);
        in_STB = 1'b0;
        check_value("extra_became_a", op_input_a, 32'h40E00000);
        send_word(32'h3F800000, 0);
        send_word(32'h40000000, 0);
        send_word(32'h3F000000, 0);
        get_resp("extra_next", 32'h40E00000);

        // Watchdog: unit never accepts.
        m_hang = 1'b1;
        send_set(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0);
        repeat (15) @(negedge clk);
        check_value("to_still_issue", {31'd0, op_input_STB}, 32'd1);
        check_value("to_no_resp_yet", {31'd0, resp_STB}, 32'd0);
        @(negedge clk);
        check_value("to_op_stb", {31'd0, op_input_STB}, 32'd0);
        check_value("to_resp_stb", {31'd0, resp_STB}, 32'd1);
        check_value("to_resp_data", resp_data, 32'h7FC00000);
        check_value("to_terr", {31'd0, timeout_err}, 32'd1);
        check_value("to_mod_busy", {31'd0, op_output_module_BUSY}, 32'd1);
        @(negedge clk);
        exp_count++;
        check_value("to_cnt", {16'd0, op_count}, 32'(exp_count));
        m_hang = 1'b0;
        m_lat  = 1;
        send_set(32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000, 0);
        get_resp("sticky", 32'h41400000);
        check_value("sticky_terr", {31'd0, timeout_err}, 32'd1);

        // Reset while waiting for the unit result.
        m_lat = 8;
        send_set(32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000, 0);
        n = 0;
        while (op_output_module_BUSY && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("mid_in_wait", {31'd0, op_output_module_BUSY}, 32'd0);
        apply_reset();
        check_value("mid_in_busy", {31'd0, in_BUSY}, 32'd0);
        check_value("mid_op_stb", {31'd0, op_input_STB}, 32'd0);
        check_value("mid_mod_busy", {31'd0, op_output_module_BUSY}, 32'd1);
        check_value("mid_resp_stb", {31'd0, resp_STB}, 32'd0);
        check_value("mid_resp_data", resp_data, 32'd0);
        check_value("mid_op_a", op_input_a, 32'd0);
        check_value("mid_op_d", op_input_d, 32'd0);
        check_value("mid_terr", {31'd0, timeout_err}, 32'd0);
        check_value("mid_cnt", {16'd0, op_count}, 32'd0);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (resp_STB) hits++;
            @(negedge clk);
        end
        check_value("mid_no_resp", 32'(hits), 32'd0);
        m_lat = 2;
        send_set(32'h3F800000, 32'h40A00000, 32'hC0000000, 32'h3E800000, 0);
        get_resp("post_rst", 32'hC0200000);

        // Back-to-back random sets.
        apply_reset();
        for (int k = 0; k < 100; k++) begin
            for (int j = 0; j < 4; j++)
                w[j] = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
            m_lat = $urandom_range(0, 4);
            send_set(w[0], w[1], w[2], w[3], 0);
            get_resp("b2b", fmul4(w[0], w[1], w[2], w[3]));
        end
        check_value("b2b_total", {16'd0, op_count}, 32'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

endmodule
`default_nettype wire
